// File: rtl/jtag_tap_ctrl.sv
// IEEE 1149.1 TAP controller front end: 16-state TAP FSM, Instruction Register and latched instruction.
// Optional raw state port tap_state[3:0] is enabled by defining JTAG_TAP_STATE_OUT_EN.
module jtag_tap_ctrl #(
  parameter int                    INSN_WIDTH  = 8,
  parameter logic [INSN_WIDTH-1:0] IDCODE_INSN = INSN_WIDTH'(8'b0000_0010)
) (
  input  logic                  tck,
  input  logic                  trst,
  input  logic                  tms,
  input  logic                  tdi,
  output logic                  state_test_logic_reset,
  output logic                  state_run_test_idle,
  output logic                  state_capture_dr,
  output logic                  state_shift_dr,
  output logic                  state_exit1_dr,
  output logic                  state_pause_dr,
  output logic                  state_update_dr,
  output logic                  state_capture_ir,
  output logic                  state_shift_ir,
  output logic                  state_update_ir,
  output logic [INSN_WIDTH-1:0] latched_jtag_ir,
  output logic                  insn_tdo
`ifdef JTAG_TAP_STATE_OUT_EN
  ,
  output logic [3:0]            tap_state
`endif
);

  typedef enum logic [3:0] {
    S_TLR      = 4'hF,
    S_RTI      = 4'hC,
    S_SEL_DR   = 4'h7,
    S_CAP_DR   = 4'h6,
    S_SH_DR    = 4'h2,
    S_EX1_DR   = 4'h1,
    S_PAUSE_DR = 4'h3,
    S_EX2_DR   = 4'h0,
    S_UPD_DR   = 4'h5,
    S_SEL_IR   = 4'h4,
    S_CAP_IR   = 4'hE,
    S_SH_IR    = 4'hA,
    S_EX1_IR   = 4'h9,
    S_PAUSE_IR = 4'hB,
    S_EX2_IR   = 4'h8,
    S_UPD_IR   = 4'hD
  } tap_state_e;

  tap_state_e            r_state;
  tap_state_e            w_next_state;
  logic [INSN_WIDTH-1:0] r_jtag_ir;
  logic [INSN_WIDTH-1:0] r_latched_ir;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge tck) begin
    if (trst) r_state <= S_TLR;
    else      r_state <= w_next_state;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_next_state           = r_state;
    state_test_logic_reset = 1'b0;
    state_run_test_idle    = 1'b0;
    state_capture_dr       = 1'b0;
    state_shift_dr         = 1'b0;
    state_exit1_dr         = 1'b0;
    state_pause_dr         = 1'b0;
    state_update_dr        = 1'b0;
    state_capture_ir       = 1'b0;
    state_shift_ir         = 1'b0;
    state_update_ir        = 1'b0;
    unique case (r_state)
      S_TLR: begin
        w_next_state           = tms ? S_TLR : S_RTI;
        state_test_logic_reset = 1'b1;
      end
      S_RTI: begin
        w_next_state        = tms ? S_SEL_DR : S_RTI;
        state_run_test_idle = 1'b1;
      end
      S_SEL_DR: w_next_state = tms ? S_SEL_IR : S_CAP_DR;
      S_CAP_DR: begin
        w_next_state     = tms ? S_EX1_DR : S_SH_DR;
        state_capture_dr = 1'b1;
      end
      S_SH_DR: begin
        w_next_state   = tms ? S_EX1_DR : S_SH_DR;
        state_shift_dr = 1'b1;
      end
      S_EX1_DR: begin
        w_next_state   = tms ? S_UPD_DR : S_PAUSE_DR;
        state_exit1_dr = 1'b1;
      end
      S_PAUSE_DR: begin
        w_next_state   = tms ? S_EX2_DR : S_PAUSE_DR;
        state_pause_dr = 1'b1;
      end
      S_EX2_DR: w_next_state = tms ? S_UPD_DR : S_SH_DR;
      S_UPD_DR: begin
        w_next_state    = tms ? S_SEL_DR : S_RTI;
        state_update_dr = 1'b1;
      end
      S_SEL_IR: w_next_state = tms ? S_TLR : S_CAP_IR;
      S_CAP_IR: begin
        w_next_state     = tms ? S_EX1_IR : S_SH_IR;
        state_capture_ir = 1'b1;
      end
      S_SH_IR: begin
        w_next_state   = tms ? S_EX1_IR : S_SH_IR;
        state_shift_ir = 1'b1;
      end
      S_EX1_IR:   w_next_state = tms ? S_UPD_IR : S_PAUSE_IR;
      S_PAUSE_IR: w_next_state = tms ? S_EX2_IR : S_PAUSE_IR;
      S_EX2_IR:   w_next_state = tms ? S_UPD_IR : S_SH_IR;
      S_UPD_IR: begin
        w_next_state    = tms ? S_SEL_DR : S_RTI;
        state_update_ir = 1'b1;
      end
    endcase
  end

  // Capture forces the mandatory 2'b01 into the low bits; shifting is LSB-first toward insn_tdo.
  always_ff @(posedge tck) begin
    if (trst) begin
      r_jtag_ir <= '0;
    end else if (r_state == S_CAP_IR) begin
      r_jtag_ir <= INSN_WIDTH'(2'b01);
    end else if (r_state == S_SH_IR) begin
      r_jtag_ir <= {tdi, r_jtag_ir[INSN_WIDTH-1:1]};
    end
  end

  always_ff @(posedge tck) begin
    if (trst || r_state == S_TLR) r_latched_ir <= IDCODE_INSN;
    else if (r_state == S_UPD_IR) r_latched_ir <= r_jtag_ir;
  end

  assign latched_jtag_ir = r_latched_ir;
  assign insn_tdo        = r_jtag_ir[0];

`ifdef JTAG_TAP_STATE_OUT_EN
  assign tap_state = r_state;
`endif

endmodule
